// File: rtl/sample_streamer.sv
// Streams N stored samples from a 1-cycle-latency RAM, each held for HOLD ready cycles.
// Latency: first sample on dout 3 cycles after start; ready=0 freezes the hold count, dout and valid.
module sample_streamer #(
    parameter int WL    = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int HOLD  = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          ready,
    output logic [AW-1:0] rd_addr,
    input  logic [WL-1:0] rd_data,
    output logic          valid,
    output logic [WL-1:0] dout,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   sent
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_S   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [7:0]    HOLD_M1 = 8'(HOLD - 1);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [WL-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW:0]   sent_q, sent_d;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sent_d    = sent_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d       = (len > DEPTH_W) ? DEPTH_W : len;
                        rd_addr_d = '0;
                        sent_d    = '0;
                        busy_d    = 1'b1;
                        state_d   = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                dout_d    = rd_data;
                valid_d   = 1'b1;
                sent_d    = ONE_S;
                rd_addr_d = rd_addr_q + ONE_A;
                cnt_d     = HOLD_M1;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                // rd_data already holds mem[sent] here: it was prefetched at the previous load edge
                if (ready) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (sent_q < n_q) begin
                        dout_d    = rd_data;
                        sent_d    = sent_q + ONE_S;
                        rd_addr_d = rd_addr_q + ONE_A;
                        cnt_d     = HOLD_M1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign valid   = valid_q;
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sent    = sent_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Directed bench for sample_streamer with a behavioural synchronous-read RAM holding mem[i] = i + 2.
module tb_sample_streamer;

    localparam int WL = 16;
    localparam int AW = 12;
    localparam int DEPTH = 4096;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW:0]   len;
    logic          ready;
    logic [AW-1:0] rd_addr;
    logic [WL-1:0] rd_data;
    logic          valid;
    logic [WL-1:0] dout;
    logic          busy;
    logic          done;
    logic [AW:0]   sent;

    logic [WL-1:0] mem [DEPTH];

    sample_streamer #(.WL(WL), .DEPTH(DEPTH), .AW(AW), .HOLD(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .valid(valid), .dout(dout),
        .busy(busy), .done(done), .sent(sent)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rd_data <= mem[rd_addr];

    typedef struct {
        logic          rst;
        logic          st;
        logic [AW:0]   ln;
        logic          rdy;
        logic          v;
        logic [WL-1:0] d;
        logic          b;
        logic          dn;
        logic [AW:0]   s;
        logic [AW-1:0] a;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input int n, input logic rst_i, input logic st_i, input int ln_i, input logic rdy_i,
                       input logic v_i, input int d_i, input logic b_i, input logic dn_i, input int s_i, input int a_i);
        vec_t r;
        r.rst = rst_i; r.st = st_i; r.ln = (AW+1)'(ln_i); r.rdy = rdy_i;
        r.v = v_i; r.d = WL'(d_i); r.b = b_i; r.dn = dn_i; r.s = (AW+1)'(s_i); r.a = AW'(a_i);
        for (int k = 0; k < n; k++) tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int            done_cyc;
    int            bad_cycles;
    logic [WL-1:0] exp_d;
    logic [AW:0]   sent_at_done;
    logic [AW-1:0] addr_at_done;
    logic          valid_at_done;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WL'(i + 2);

        // {rst, start, len, ready} -> {valid, dout, busy, done, sent, rd_addr}
        // basic stream, len=4
        add(1, 0, 1, 4, 1,  0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        add(3, 0, 0, 0, 1,  1, 2, 1, 0, 1, 1);
        add(3, 0, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(3, 0, 0, 0, 1,  1, 4, 1, 0, 3, 3);
        add(3, 0, 0, 0, 1,  1, 5, 1, 0, 4, 4);
        add(1, 0, 0, 0, 1,  0, 5, 0, 1, 4, 4);
        add(1, 0, 0, 0, 1,  0, 5, 0, 0, 4, 4);
        // stall: ready=0 in cycles 7..9, new start in the done cycle
        add(1, 0, 1, 4, 1,  0, 5, 0, 0, 4, 4);
        add(2, 0, 0, 0, 1,  0, 5, 1, 0, 0, 0);
        add(3, 0, 0, 0, 1,  1, 2, 1, 0, 1, 1);
        add(1, 0, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(3, 0, 0, 0, 0,  1, 3, 1, 0, 2, 2);
        add(2, 0, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(3, 0, 0, 0, 1,  1, 4, 1, 0, 3, 3);
        add(3, 0, 0, 0, 1,  1, 5, 1, 0, 4, 4);
        add(1, 0, 1, 2, 1,  0, 5, 0, 1, 4, 4);
        // second stream, len=2, start while busy at cycle 5 ignored
        add(2, 0, 0, 0, 1,  0, 5, 1, 0, 0, 0);
        add(2, 0, 0, 0, 1,  1, 2, 1, 0, 1, 1);
        add(1, 0, 1, 1, 1,  1, 2, 1, 0, 1, 1);
        add(3, 0, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(1, 0, 0, 0, 1,  0, 3, 0, 1, 2, 2);
        // mid-stream reset at cycle 8, RST beats start, len=0, then len=1 from address 0
        add(1, 0, 1, 4, 1,  0, 3, 0, 0, 2, 2);
        add(2, 0, 0, 0, 1,  0, 3, 1, 0, 0, 0);
        add(3, 0, 0, 0, 1,  1, 2, 1, 0, 1, 1);
        add(2, 0, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(1, 1, 0, 0, 1,  1, 3, 1, 0, 2, 2);
        add(1, 1, 1, 4, 1,  0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1,  0, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        add(3, 0, 0, 0, 1,  1, 2, 1, 0, 1, 1);
        add(1, 0, 0, 0, 1,  0, 2, 0, 1, 1, 1);

        // reset with arbitrary inputs active
        RST = 1'b1; start = 1'b1; len = 13'd3; ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset", 64'({valid, dout, busy, done, sent, rd_addr}), 64'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK);
            #1;
            RST = tbl[i].rst; start = tbl[i].st; len = tbl[i].ln; ready = tbl[i].rdy;
            @(negedge CLK);
            chk($sformatf("vec%0d", i), 64'({valid, dout, busy, done, sent, rd_addr}),
                64'({tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].dn, tbl[i].s, tbl[i].a}));
        end

        // len=5000 clamps to DEPTH; every sample must appear for exactly 3 cycles
        @(posedge CLK);
        #1;
        RST = 1'b0; start = 1'b1; len = 13'd5000; ready = 1'b1;
        @(negedge CLK);
        done_cyc = -1;
        bad_cycles = 0;
        sent_at_done = '0; addr_at_done = '1; valid_at_done = 1'b1;
        for (int c = 1; c <= 12400 && done_cyc < 0; c++) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            @(negedge CLK);
            if (done) begin
                done_cyc = c;
                sent_at_done = sent; addr_at_done = rd_addr; valid_at_done = valid;
            end else if (c >= 3) begin
                exp_d = WL'((c - 3) / 3 + 2);
                if (!valid || dout !== exp_d || !busy) bad_cycles++;
            end else if (!busy || valid) begin
                bad_cycles++;
            end
        end
        chk("clamp_done_cycle", 64'(done_cyc), 64'(12291));
        chk("clamp_stream_cycles", 64'(bad_cycles), 64'(0));
        chk("clamp_sent", 64'(sent_at_done), 64'(4096));
        chk("clamp_rd_addr_wrap", 64'(addr_at_done), 64'(0));
        chk("clamp_valid_low", 64'(valid_at_done), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_streamer.md
Name: sample_streamer

Overview:
- Transmit-side source for moving_avg. Streams a stored block of samples from a synchronous-read sample RAM onto a valid/din-style output.
- Each sample is held for exactly HOLD enabled cycles, matching the sample cadence moving_avg consumes.
- Replaces hand-written stimulus loops in front of moving_avg, both in the datapath and in system-level benches.

Parameters:
- WL, 16, sample word width (matches moving_avg WL).
- DEPTH, 4096, sample RAM depth in words.
- AW, 12, RAM address width; must equal clog2(DEPTH).
- HOLD, 3, enabled cycles each sample is presented on dout; legal range 2..255.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  1-cycle request to stream len samples from address 0; ignored while busy=1.
- len  input  AW+1  number of samples to stream, sampled with start; 0 is legal; values above DEPTH are clamped to DEPTH.
- ready  input  1  downstream enable; 0 freezes the hold counter, dout and valid.
- rd_addr  output  AW  registered RAM read address.
- rd_data  input  WL  RAM read data; reflects rd_addr of the previous cycle (1-cycle latency).
- valid  output  1  dout carries a live sample.
- dout  output  WL  sample to moving_avg din.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  1-cycle pulse at end of stream.
- sent  output  AW+1  samples emitted so far in the current stream; holds its value after done.

Behaviour:
- Reset (RST=1 at an edge): state IDLE. valid=0, dout=0, rd_addr=0, busy=0, done=0, sent=0, hold counter=0. RST mid-stream aborts immediately with no done pulse.
- FSM states: IDLE, PRIME, LOAD, STREAM.
- IDLE:
  - start=1 and len≠0: latch min(len,DEPTH) as N; set rd_addr=0, sent=0, busy=1; go to PRIME.
  - start=1 and len=0: done=1 next cycle; stay IDLE; busy stays 0.
- PRIME: 1 cycle. RAM samples address 0. Go to LOAD.
- LOAD: 1 cycle; rd_data=mem[0]. At the closing edge: dout<=rd_data, valid<=1, sent<=1, rd_addr<=1 (wrap to 0 if N=1 is irrelevant), cnt<=HOLD-1; go to STREAM.
- STREAM, ready=0: all registers hold.
- STREAM, ready=1 and cnt≠0: cnt<=cnt-1.
- STREAM, ready=1 and cnt=0 (last hold cycle):
  - sent<N: dout<=rd_data (the prefetched mem[sent]); sent<=sent+1; rd_addr<=rd_addr+1; cnt<=HOLD-1.
  - sent=N: valid<=0, busy<=0, done<=1 for one cycle, dout holds its last value; go to IDLE.
- Prefetch: rd_addr advances at each load edge, so next-sample data is valid from the 2nd hold cycle on. This is why HOLD≥2.
- rd_addr never exceeds N-1 as a consumed address; the increment after the final load is don't-care but must stay in AW bits (wraps).
- Timing, start accepted in cycle 0, ready held 1:
  - valid rises in cycle 3.
  - dout=mem[k] in cycles 3+k·HOLD … 2+(k+1)·HOLD.
  - done=1 and valid=0 in cycle 3+N·HOLD.
- valid stays continuously high across sample boundaries; there are no gaps between samples.
- Simultaneous events:
  - start while busy: ignored.
  - start in the same cycle done is asserted: accepted, since state is already IDLE.
  - RST together with start: RST wins.
- done and start are independent of ready. ready is only examined in STREAM.

Test Plan:
- Reset check: RST=1 for 2 cycles, any inputs -> valid=0, dout=0, busy=0, done=0, rd_addr=0, sent=0.
- Basic stream: RAM[0..3]={2,3,4,5}, HOLD=3, len=4, ready=1, start in cycle 0 -> dout=2 in cycles 3–5, 3 in 6–8, 4 in 9–11, 5 in 12–14; valid=1 in cycles 3–14; done=1 and valid=0 in cycle 15; sent=4.
- Stall: same setup, ready=0 in cycles 7–9 -> dout=3 held in cycles 6–11, later samples shifted by 3 cycles, done in cycle 18.
- Edge lengths: len=0 -> done pulse in cycle 1, busy never set. len=5000 -> clamps to 4096, rd_addr wraps cleanly, done at cycle 3+4096·3=12291.
- Protocol corners: start re-asserted at cycle 5 of a stream -> ignored, stream unchanged. New start in the done cycle -> second stream begins, valid again 3 cycles later.
- Mid-stream reset: RST=1 at cycle 8 -> next cycle all outputs at reset values, no done pulse. Following start streams from address 0.
